// File: rtl/wide_narrow_pkg.sv
// Shared definitions for the wide-to-narrow sequencer.
// Contents:
//   state_e - controller state (StIdle waits for a wide word, StEmit streams its chunks).
// Chunk count and select widths depend on instance parameters and are derived locally.
package wide_narrow_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StEmit = 1'b1
    } state_e;

endpackage

// File: rtl/wide_chunk_select.sv
// Combinational chunk selector: picks chunk sel_i of a wide word and zero-extends it.
// Ports:
//   word_i  [INPUT_W]  wide word, chunk 0 in the least significant bits
//   sel_i   [DIFF_W]   chunk index, 0 .. CHUNKS-1
//   chunk_o [OUTPUT_W] selected chunk, zero-extended
module wide_chunk_select #(
    parameter int unsigned INPUT_W  = 64,
    parameter int unsigned SIZE_W   = 32,
    parameter int unsigned OUTPUT_W = 32,
    localparam int unsigned CHUNKS  = INPUT_W / SIZE_W,
    localparam int unsigned DIFF_W  = $clog2(CHUNKS)
) (
    input  logic [INPUT_W-1:0]  word_i,
    input  logic [DIFF_W-1:0]   sel_i,
    output logic [OUTPUT_W-1:0] chunk_o
);

    // Explicit mux over every chunk position; indices outside 0..CHUNKS-1 yield zero.
    always_comb begin
        chunk_o = '0;
        for (int unsigned i = 0; i < CHUNKS; i++) begin
            if (sel_i == DIFF_W'(i)) begin
                chunk_o[SIZE_W-1:0] = word_i[i*SIZE_W +: SIZE_W];
            end
        end
    end

endmodule

// File: rtl/wide_narrow_sequencer.sv
// Wide-to-narrow streaming sequencer.
// Accepts INPUT_W words over a valid/ready handshake and emits them as SIZE_W chunks,
// lowest chunk first, each zero-extended to OUTPUT_W. A new word can be accepted on the
// same cycle the final chunk of the previous word is taken, so there is no bubble.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i / in_ready_o / in_data_i / in_last_i    wide word input
//   out_valid_o / out_ready_i / out_data_o / out_last_o chunk output
//   busy_o       high while chunks of a word are being emitted
//   count_i      chunks valid in the offered word (only with WIDE_NARROW_COUNT_EN)
// Build option:
//   WIDE_NARROW_COUNT_EN - adds count_i; count_i of 0 or above CHUNKS means a full word.
module wide_narrow_sequencer
    import wide_narrow_pkg::*;
#(
    parameter int unsigned INPUT_W  = 64,
    parameter int unsigned SIZE_W   = 32,
    parameter int unsigned OUTPUT_W = 32,
    localparam int unsigned CHUNKS  = INPUT_W / SIZE_W,
    localparam int unsigned DIFF_W  = $clog2(CHUNKS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [INPUT_W-1:0]  in_data_i,
    input  logic                in_last_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [OUTPUT_W-1:0] out_data_o,
    output logic                out_last_o,
    output logic                busy_o
`ifdef WIDE_NARROW_COUNT_EN
    ,
    input  logic [DIFF_W:0]     count_i
`endif
);

    localparam logic [DIFF_W-1:0] FullLastSel = DIFF_W'(CHUNKS - 1);

    state_e             state_q, state_d;
    logic [INPUT_W-1:0] hold_q, hold_d;
    logic               hold_last_q, hold_last_d;
    logic [DIFF_W-1:0]  sel_q, sel_d;
    logic [DIFF_W-1:0]  last_sel_q, last_sel_d;
    logic [DIFF_W-1:0]  load_last_sel;
    logic               at_last;

    // Index of the final chunk for the word being offered.
`ifdef WIDE_NARROW_COUNT_EN
    always_comb begin
        if ((count_i == '0) || (count_i > (DIFF_W + 1)'(CHUNKS))) begin
            load_last_sel = FullLastSel;
        end else begin
            load_last_sel = DIFF_W'(count_i - (DIFF_W + 1)'(1));
        end
    end
`else
    assign load_last_sel = FullLastSel;
`endif

    assign at_last = (sel_q == last_sel_q);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        sel_d       = sel_q;
        last_sel_d  = last_sel_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
            end
            StEmit: begin
                out_valid_o = 1'b1;
                busy_o      = 1'b1;
                if (out_ready_i) begin
                    if (at_last) begin
                        // Final chunk leaves this cycle: the input slot opens up now.
                        in_ready_o = 1'b1;
                        if (!in_valid_i) begin
                            state_d = StIdle;
                        end
                    end else begin
                        sel_d = sel_q + DIFF_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rst_i) begin
            in_ready_o = 1'b0;
        end

        if (in_valid_i && in_ready_o) begin
            state_d     = StEmit;
            hold_d      = in_data_i;
            hold_last_d = in_last_i;
            sel_d       = '0;
            last_sel_d  = load_last_sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            sel_q       <= '0;
            last_sel_q  <= FullLastSel;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            sel_q       <= sel_d;
            last_sel_q  <= last_sel_d;
        end
    end

    wide_chunk_select #(
        .INPUT_W  (INPUT_W),
        .SIZE_W   (SIZE_W),
        .OUTPUT_W (OUTPUT_W)
    ) u_chunk_select (
        .word_i  (hold_q),
        .sel_i   (sel_q),
        .chunk_o (out_data_o)
    );

    assign out_last_o = out_valid_o & hold_last_q & at_last;

endmodule

// File: tb/tb_wide_narrow_sequencer.sv
// Self-checking bench for wide_narrow_sequencer.
// Two instances run side by side: dut_a (64/32/32, two chunks per word) and
// dut_b (64/16/32, four zero-extended chunks per word). A chunk-queue reference model
// predicts every handshake and output each cycle; directed steps add literal checks.
// Honours WIDE_NARROW_COUNT_EN when defined.
module tb_wide_narrow_sequencer;

    logic clk = 1'b0;
    logic rst;

    logic        iv_a, il_a, or_a;
    logic [63:0] id_a;
    logic        ir_a, ov_a, ol_a, bz_a;
    logic [31:0] od_a;

    logic        iv_b, il_b, or_b;
    logic [63:0] id_b;
    logic        ir_b, ov_b, ol_b, bz_b;
    logic [31:0] od_b;

`ifdef WIDE_NARROW_COUNT_EN
    logic [1:0] cnt_a;
    logic [2:0] cnt_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Expected chunks still to come from each DUT: {last, data}.
    logic [32:0] qa[$];
    logic [32:0] qb[$];
    // Set once a reset edge has passed with no word loaded since: hold register is zero.
    bit clean[2] = '{0, 0};

    always #5 clk = ~clk;

    wide_narrow_sequencer #(
        .INPUT_W  (64),
        .SIZE_W   (32),
        .OUTPUT_W (32)
    ) dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (iv_a),
        .in_ready_o  (ir_a),
        .in_data_i   (id_a),
        .in_last_i   (il_a),
        .out_valid_o (ov_a),
        .out_ready_i (or_a),
        .out_data_o  (od_a),
        .out_last_o  (ol_a),
        .busy_o      (bz_a)
`ifdef WIDE_NARROW_COUNT_EN
        ,
        .count_i     (cnt_a)
`endif
    );

    wide_narrow_sequencer #(
        .INPUT_W  (64),
        .SIZE_W   (16),
        .OUTPUT_W (32)
    ) dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (iv_b),
        .in_ready_o  (ir_b),
        .in_data_i   (id_b),
        .in_last_i   (il_b),
        .out_valid_o (ov_b),
        .out_ready_i (or_b),
        .out_data_o  (od_b),
        .out_last_o  (ol_b),
        .busy_o      (bz_b)
`ifdef WIDE_NARROW_COUNT_EN
        ,
        .count_i     (cnt_b)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare one DUT against the model for the current cycle, then advance the model
    // to what the coming clock edge will do.
    task automatic check_dut(input int d, input logic ir, input logic ov, input logic ol,
                             input logic bz, input logic [31:0] od, input logic iv,
                             input logic ordy, input logic il, input logic [63:0] wd,
                             input int cnt);
        logic [32:0] q[$];
        logic [32:0] head;
        logic [63:0] shifted;
        logic [31:0] piece;
        logic        exp_ir;
        int          chunks, sw, c;
        string       p;
        if (d == 0) begin
            q = qa; chunks = 2; sw = 32; p = "a";
        end else begin
            q = qb; chunks = 4; sw = 16; p = "b";
        end
        exp_ir = !rst && ((q.size() == 0) || ((q.size() == 1) && ordy));
        chk({p, "_in_ready"}, 64'(ir), 64'(exp_ir));
        if (rst) begin
            if (clean[d]) begin
                chk({p, "_rst_valid"}, 64'(ov), 64'd0);
                chk({p, "_rst_busy"}, 64'(bz), 64'd0);
                chk({p, "_rst_data"}, 64'(od), 64'd0);
            end
            q.delete();
            clean[d] = 1;
        end else begin
            chk({p, "_out_valid"}, 64'(ov), 64'(q.size() != 0));
            chk({p, "_busy"}, 64'(bz), 64'(q.size() != 0));
            if (q.size() != 0) begin
                head = q[0];
                chk({p, "_out_data"}, 64'(od), 64'(head[31:0]));
                chk({p, "_out_last"}, 64'(ol), 64'(head[32]));
                if (ordy) void'(q.pop_front());
            end else if (clean[d]) begin
                chk({p, "_idle_data"}, 64'(od), 64'd0);
                chk({p, "_idle_last"}, 64'(ol), 64'd0);
            end
            if (iv && exp_ir) begin
                c = chunks;
                if (cnt > 0 && cnt <= chunks) c = cnt;
                for (int k = 0; k < c; k++) begin
                    shifted = wd >> (k * sw);
                    piece   = (sw == 32) ? shifted[31:0] : {16'h0, shifted[15:0]};
                    q.push_back({il && (k == c - 1), piece});
                end
                clean[d] = 0;
            end
        end
        if (d == 0) qa = q; else qb = q;
    endtask

    // Called just after a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle();
        int ca, cb;
        ca = 0;
        cb = 0;
`ifdef WIDE_NARROW_COUNT_EN
        ca = int'(cnt_a);
        cb = int'(cnt_b);
`endif
        #1;
        check_dut(0, ir_a, ov_a, ol_a, bz_a, od_a, iv_a, or_a, il_a, id_a, ca);
        check_dut(1, ir_b, ov_b, ol_b, bz_b, od_b, iv_b, or_b, il_b, id_b, cb);
        @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        iv_a = 1'b0; il_a = 1'b0; or_a = 1'b1; id_a = '0;
        iv_b = 1'b0; il_b = 1'b0; or_b = 1'b1; id_b = '0;
`ifdef WIDE_NARROW_COUNT_EN
        cnt_a = '0;
        cnt_b = '0;
`endif
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // Single word on each DUT, consumer always ready.
        id_a = 64'h1111_2222_3333_4444; il_a = 1'b1; iv_a = 1'b1;
        id_b = 64'hAAAA_BBBB_CCCC_DDDD; il_b = 1'b1; iv_b = 1'b1;
        cycle();
        iv_a = 1'b0; iv_b = 1'b0;
        chk("a_chunk0", 64'(od_a), 64'h3333_4444);
        chk("a_last0", 64'(ol_a), 64'd0);
        chk("b_chunk0", 64'(od_b), 64'h0000_DDDD);
        cycle();
        chk("a_chunk1", 64'(od_a), 64'h1111_2222);
        chk("a_last1", 64'(ol_a), 64'd1);
        chk("b_chunk1", 64'(od_b), 64'h0000_CCCC);
        cycle();
        chk("a_back_idle", 64'(ov_a), 64'd0);
        chk("b_chunk2", 64'(od_b), 64'h0000_BBBB);
        cycle();
        chk("b_chunk3", 64'(od_b), 64'h0000_AAAA);
        chk("b_last3", 64'(ol_b), 64'd1);
        cycle();
        chk("b_back_idle", 64'(ov_b), 64'd0);

        // Backpressure on chunk 0.
        id_a = 64'h1111_2222_3333_4444; il_a = 1'b0; iv_a = 1'b1;
        cycle();
        iv_a = 1'b0; or_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("a_bp_ready", 64'(ir_a), 64'd0);
            cycle();
            chk("a_bp_hold", 64'(od_a), 64'h3333_4444);
        end
        or_a = 1'b1;
        cycle();
        chk("a_bp_resume", 64'(od_a), 64'h1111_2222);
        cycle();

        // Back-to-back words with no bubble.
        id_a = 64'h0102_0304_0506_0708; il_a = 1'b0; iv_a = 1'b1;
        cycle();
        chk("a_b2b_c0", 64'(od_a), 64'h0506_0708);
        id_a = 64'h1112_1314_1516_1718; il_a = 1'b1;
        cycle();
        chk("a_b2b_c1", 64'(od_a), 64'h0102_0304);
        #1 chk("a_b2b_ready", 64'(ir_a), 64'd1);
        cycle();
        iv_a = 1'b0;
        chk("a_b2b_c2", 64'(od_a), 64'h1516_1718);
        cycle();
        chk("a_b2b_c3", 64'(od_a), 64'h1112_1314);
        chk("a_b2b_last", 64'(ol_a), 64'd1);
        cycle();

        // Reset while emitting.
        id_a = 64'h9999_8888_7777_6666; il_a = 1'b1; iv_a = 1'b1;
        cycle();
        iv_a = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("a_rst_valid", 64'(ov_a), 64'd0);
        chk("a_rst_data", 64'(od_a), 64'd0);
        #1 chk("a_rst_ready", 64'(ir_a), 64'd1);
        id_a = 64'h5555_6666_7777_8888; iv_a = 1'b1;
        cycle();
        iv_a = 1'b0;
        chk("a_restart_c0", 64'(od_a), 64'h7777_8888);
        cycle();
        cycle();

`ifdef WIDE_NARROW_COUNT_EN
        // Partial word: single chunk, flagged last.
        cnt_b = 3'd1; id_b = 64'hAAAA_BBBB_CCCC_DDDD; il_b = 1'b1; iv_b = 1'b1;
        cycle();
        iv_b = 1'b0;
        chk("b_cnt1_data", 64'(od_b), 64'h0000_DDDD);
        chk("b_cnt1_last", 64'(ol_b), 64'd1);
        cycle();
        chk("b_cnt1_done", 64'(ov_b), 64'd0);
        // count 0 means a full word.
        cnt_b = 3'd0; iv_b = 1'b1;
        cycle();
        iv_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("b_cnt0_busy", 64'(ov_b), 64'd1);
            cycle();
        end
        chk("b_cnt0_c3", 64'(od_b), 64'h0000_AAAA);
        cycle();
`endif

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            rst  = ($urandom_range(0, 79) == 0);
            iv_a = ($urandom_range(0, 3) != 0);
            or_a = ($urandom_range(0, 3) != 0);
            il_a = ($urandom_range(0, 1) == 1);
            id_a = {$urandom, $urandom};
            iv_b = ($urandom_range(0, 3) != 0);
            or_b = ($urandom_range(0, 3) != 0);
            il_b = ($urandom_range(0, 1) == 1);
            id_b = {$urandom, $urandom};
`ifdef WIDE_NARROW_COUNT_EN
            cnt_a = 2'($urandom_range(0, 3));
            cnt_b = 3'($urandom_range(0, 7));
`endif
            cycle();
        end

        rst = 1'b0; iv_a = 1'b0; iv_b = 1'b0; or_a = 1'b1; or_b = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
